vin_quadencoder: RTL and testbench



---
 rtl/vin_quadencoder.sv | 180 ++++++++++++++++++
 tb/tb_vin_quadencoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vin_quadencoder.sv
// rtl/vin_quadencoder.sv - quadrature encoder input stage; optional index reset via VIN_QUADENCODER_INDEX_EN
module vin_quadencoder #(
    parameter int FILTER_LEN = 3,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 QUAD_A,
    input  logic                 QUAD_B,
    input  logic                 QUAD_Z,
    input  logic                 clear,
    input  logic                 indexEnable,
    output logic [31:0]          position,
    output logic [ERR_WIDTH-1:0] errorCount,
    output logic                 indexDone
);

    // Channel bit order inside the pin vectors: 0 = A, 1 = B, 2 = Z.
    localparam int         CH_A      = 0;
    localparam int         CH_B      = 1;
    localparam int         CH_Z      = 2;
    localparam logic [3:0] FILT_MAX  = 4'(FILTER_LEN);
    localparam logic [4:0] INIT_LAST = 5'(FILTER_LEN + 2);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [2:0]             pins;
    logic [2:0]             sync1_q;
    logic [2:0]             sync2_q;
    logic [2:0]             filt_q;
    logic [2:0][3:0]        fcnt_q;
    logic [4:0]             init_cnt_q;
    logic [1:0]             prev_q;
    logic [1:0]             cur_ab;
    logic                   step_fwd;
    logic                   step_rev;
    logic                   illegal;
    logic                   index_zero;
    logic [31:0]            pos_q;
    logic [31:0]            pos_d;
    logic [ERR_WIDTH-1:0]   err_q;

    assign pins   = {QUAD_Z, QUAD_B, QUAD_A};
    assign cur_ab = {filt_q[CH_A], filt_q[CH_B]};

    // Two-flop synchroniser for the asynchronous encoder pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pins;
            sync2_q <= sync1_q;
        end
    end

    // Glitch filter: a new level must persist FILTER_LEN cycles before it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            fcnt_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] + 4'd1 == FILT_MAX) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 4'd1;
                end
            end
        end
    end

    // State register plus the startup settle counter and previous A/B snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            prev_q     <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= cur_ab;
            if (state_q == ST_INIT) begin
                init_cnt_q <= init_cnt_q + 5'd1;
            end else begin
                init_cnt_q <= '0;
            end
        end
    end

    // Next state and 4x decode; INIT only lets the filters settle, nothing is counted.
    always_comb begin
        state_d  = state_q;
        step_fwd = 1'b0;
        step_rev = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                case ({prev_q, cur_ab})
                    4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd = 1'b1;
                    4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_rev = 1'b1;
                    4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal  = 1'b1;
                    default: ;
                endcase
            end
            default: state_d = ST_INIT;
        endcase
    end

`ifdef VIN_QUADENCODER_INDEX_EN
    logic z_prev_q;
    logic done_q;

    assign index_zero = (state_q == ST_RUN) && filt_q[CH_Z] && !z_prev_q
                        && indexEnable && !done_q;
    assign indexDone  = done_q;

    // Index handshake: zero once per indexEnable session, release when the host drops the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_prev_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            z_prev_q <= filt_q[CH_Z];
            if (index_zero) begin
                done_q <= 1'b1;
            end else if (!indexEnable) begin
                done_q <= 1'b0;
            end
        end
    end
`else
    logic unused_index;

    assign index_zero   = 1'b0;
    assign indexDone    = 1'b0;
    assign unused_index = ^{indexEnable, filt_q[CH_Z]};
`endif

    // Position update: index zero and clear override any count step in the same cycle.
    always_comb begin
        pos_d = pos_q;
        if (index_zero || clear) begin
            pos_d = '0;
        end else if (step_fwd) begin
            pos_d = pos_q + 32'd1;
        end else if (step_rev) begin
            pos_d = pos_q - 32'd1;
        end
    end

    // Position and saturating illegal-transition counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
            err_q <= '0;
        end else begin
            pos_q <= pos_d;
            if (illegal && (err_q != '1)) begin
                err_q <= err_q + ERR_WIDTH'(1);
            end
        end
    end

    assign position   = pos_q;
    assign errorCount = err_q;

endmodule

// File: tb/tb_vin_quadencoder.sv
// tb/tb_vin_quadencoder.sv - directed bench for vin_quadencoder
module tb_vin_quadencoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        quad_a;
    logic        quad_b;
    logic        quad_z;
    logic        clear;
    logic        index_enable;
    logic [31:0] position;
    logic [7:0]  error_count;
    logic        index_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        a;
        logic        b;
        logic        clr;
        int          hold;
        logic [31:0] pos;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs[16];

    vin_quadencoder #(.FILTER_LEN(3), .ERR_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .QUAD_A      (quad_a),
        .QUAD_B      (quad_b),
        .QUAD_Z      (quad_z),
        .clear       (clear),
        .indexEnable (index_enable),
        .position    (position),
        .errorCount  (error_count),
        .indexDone   (index_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [1:0] fwd(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Pulse A for len clocks from the current level, then watch; reports whether position left base
    // and whether it reached base+1.
    task automatic pulse_a(input int len, input logic [31:0] base, output logic moved, output logic saw_up);
        moved  = 1'b0;
        saw_up = 1'b0;
        quad_a = ~quad_a;
        for (int i = 0; i < len + 14; i++) begin
            if (i == len) quad_a = ~quad_a;
            @(negedge clk);
            if (position !== base) moved = 1'b1;
            if (position === base + 32'd1) saw_up = 1'b1;
        end
    endtask

    initial begin
        logic [1:0] ab;
        logic       moved;
        logic       saw_up;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 10, 32'd1, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 10, 32'd2, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 10, 32'd3, 8'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 10, 32'd4, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 10, 32'd5, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 10, 32'd6, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 10, 32'd7, 8'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 10, 32'd8, 8'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 10, 32'd7, 8'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 10, 32'd6, 8'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 10, 32'd5, 8'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 10, 32'd6, 8'd0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 10, 32'd6, 8'd1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 10, 32'd7, 8'd1};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 10, 32'd0, 8'd1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 10, 32'd1, 8'd1};

        // Reset with A=B=1 held.
        rst_n        = 1'b0;
        quad_a       = 1'b1;
        quad_b       = 1'b1;
        quad_z       = 1'b0;
        clear        = 1'b0;
        index_enable = 1'b0;
        wait_clks(3);
        check("reset_position", position, 32'd0);
        check("reset_errors", {24'd0, error_count}, 32'd0);
        check("reset_index_done", {31'd0, index_done}, 32'd0);
        rst_n = 1'b1;
        wait_clks(12);
        check("idle_position", position, 32'd0);
        check("idle_errors", {24'd0, error_count}, 32'd0);

        // Forward/reverse/illegal/clear vectors.
        for (int i = 0; i < 16; i++) begin
            quad_a = vecs[i].a;
            quad_b = vecs[i].b;
            clear  = vecs[i].clr;
            wait_clks(vecs[i].hold);
            check($sformatf("vec%0d_position", i), position, vecs[i].pos);
            check($sformatf("vec%0d_errors", i), {24'd0, error_count}, {24'd0, vecs[i].err});
        end
        clear = 1'b0;

        // Short pulse is filtered out; a 3-clock pulse counts up then back.
        pulse_a(2, 32'd1, moved, saw_up);
        check("pulse2_moved", {31'd0, moved}, 32'd0);
        check("pulse2_errors", {24'd0, error_count}, 32'd1);
        pulse_a(3, 32'd1, moved, saw_up);
        check("pulse3_counted", {31'd0, saw_up}, 32'd1);
        check("pulse3_final", position, 32'd1);
        check("pulse3_errors", {24'd0, error_count}, 32'd1);

        // Clear coinciding exactly with the decode cycle of a forward step (00->10).
        quad_a = 1'b1;
        quad_b = 1'b0;
        wait_clks(5);
        check("latency_before_clear", position, 32'd1);
        clear = 1'b1;
        wait_clks(1);
        clear = 1'b0;
        check("clear_with_step", position, 32'd0);
        wait_clks(10);
        check("clear_with_step_hold", position, 32'd0);

        // Latency: 10->11 visible only after 2 + FILTER_LEN + 1 clocks.
        quad_b = 1'b1;
        wait_clks(5);
        check("latency_5", position, 32'd0);
        wait_clks(1);
        check("latency_6", position, 32'd1);

        // 300 illegal jumps saturate the 8-bit counter.
        for (int i = 0; i < 300; i++) begin
            quad_a = (i % 2 != 0);
            quad_b = (i % 2 != 0);
            wait_clks(5);
        end
        wait_clks(8);
        check("saturate_errors", {24'd0, error_count}, 32'd255);
        check("saturate_position", position, 32'd1);

        // Wrap at the signed limit and below zero.
        dut.pos_q = 32'h7FFF_FFFF;
        quad_a = 1'b0;
        quad_b = 1'b1;
        wait_clks(10);
        check("wrap_positive", position, 32'h8000_0000);
        clear = 1'b1;
        wait_clks(1);
        clear = 1'b0;
        check("clear_level", position, 32'd0);
        quad_a = 1'b1;
        wait_clks(10);
        check("wrap_negative", position, 32'hFFFF_FFFF);
        clear = 1'b1;
        wait_clks(1);
        clear = 1'b0;

        // Count up to 40.
        ab = 2'b11;
        for (int i = 0; i < 40; i++) begin
            ab     = fwd(ab);
            quad_a = ab[1];
            quad_b = ab[0];
            wait_clks(8);
        end
        check("count_40", position, 32'd40);
        check("errors_kept", {24'd0, error_count}, 32'd255);

        // Index handshake.
        index_enable = 1'b1;
        quad_z = 1'b1;
        wait_clks(8);
        quad_z = 1'b0;
        wait_clks(8);
`ifdef VIN_QUADENCODER_INDEX_EN
        check("index_position", position, 32'd0);
        check("index_done_set", {31'd0, index_done}, 32'd1);
`else
        check("index_position", position, 32'd40);
        check("index_done_set", {31'd0, index_done}, 32'd0);
`endif
        quad_z = 1'b1;
        wait_clks(8);
        quad_z = 1'b0;
        quad_a = 1'b0;
        wait_clks(10);
`ifdef VIN_QUADENCODER_INDEX_EN
        check("index_second_z", position, 32'd1);
        check("index_done_held", {31'd0, index_done}, 32'd1);
`else
        check("index_second_z", position, 32'd41);
        check("index_done_held", {31'd0, index_done}, 32'd0);
`endif
        index_enable = 1'b0;
        wait_clks(1);
        check("index_done_cleared", {31'd0, index_done}, 32'd0);

        // Asynchronous reset mid-run.
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_position", position, 32'd0);
        check("async_reset_errors", {24'd0, error_count}, 32'd0);
        check("async_reset_done", {31'd0, index_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
